// File: rtl/freq_pulse_gen.sv
// freq_pulse_gen
// Produces exactly freq_hz ticks per second from clk using a Bresenham-style
// accumulator, plus a square wave that toggles on every tick. The tick stream
// is re-phased on every 1-second pulse (sec_i), and the number of ticks
// emitted in each closed 1-second window is reported as a self-check.
//
// Frequency handshake (valid/ready): a frequency word on freq_hz_i transfers
// on any rising clk edge where freq_vld_i and freq_rdy_o are both high and
// rst is low. freq_rdy_o drops only while the block waits in ARM for the
// next sec_i, so a new request is held off until the current one is aligned.
//
// Debug: dbg_state exposes the FSM state register (0=IDLE, 1=ARM, 2=RUN).
module freq_pulse_gen #(
    parameter int SYS_PRD_NS = 10,
    parameter int C_F_SYS    = 1000000000 / SYS_PRD_NS,
    parameter int C_CNT_BW   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sec_i,
    input  logic [C_CNT_BW-1:0] freq_hz_i,
    input  logic                freq_vld_i,
    output logic                freq_rdy_o,
    output logic                tick_o,
    output logic                sq_o,
    output logic [C_CNT_BW-1:0] tick_cnt_o,
    output logic                tick_cnt_vld_o,
    output logic                ovr_o,
    output logic                phase_err_o,
    output logic                sec_lost_o,
    output logic [1:0]          dbg_state
);

    // Accumulator holds a value below C_F_SYS; one extra bit lets acc + freq
    // (at most 1.5 * C_F_SYS) be formed without any wrap handling.
    // The accumulator is assumed no wider than the frequency field.
    localparam int ACC_W = $clog2(C_F_SYS) + 1;
    // Timeout counter spans 0 .. 2*C_F_SYS-1.
    localparam int TO_W  = $clog2(2 * C_F_SYS);

    localparam logic [C_CNT_BW-1:0] FREQ_MAX   = C_CNT_BW'(C_F_SYS / 2);
    localparam logic [ACC_W-1:0]    FREQ_MAX_A = ACC_W'(C_F_SYS / 2);
    localparam logic [ACC_W-1:0]    F_SYS_A    = ACC_W'(C_F_SYS);
    localparam logic [TO_W-1:0]     TO_LAST    = TO_W'(2 * C_F_SYS - 1);
    localparam logic [C_CNT_BW-1:0] CNT_MAX    = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [ACC_W-1:0]    freq_q, freq_d;
    logic [C_CNT_BW-1:0] cnt_q, cnt_d;
    logic [TO_W-1:0]     to_q, to_d;
    logic                tick_q, tick_d;
    logic                sq_q, sq_d;
    logic [C_CNT_BW-1:0] tick_cnt_q, tick_cnt_d;
    logic                tick_cnt_vld_q, tick_cnt_vld_d;
    logic                ovr_q, ovr_d;
    logic                phase_err_q, phase_err_d;
    logic                sec_lost_q, sec_lost_d;

    logic                rdy;
    logic                load;
    logic                load_over;
    logic                load_zero;
    logic [ACC_W-1:0]    load_freq;
    logic [ACC_W-1:0]    sum_run;
    logic                wrap;
    logic [ACC_W-1:0]    acc_wrapped;
    logic                to_hit;
    logic [TO_W-1:0]     to_next;
    logic [C_CNT_BW-1:0] cnt_next;

    // Request decode: handshake, clamping to Nyquist and the zero (stop) case.
    always_comb begin
        rdy       = (state_q != ST_ARM);
        load      = freq_vld_i & rdy;
        load_over = (freq_hz_i > FREQ_MAX);
        load_zero = (freq_hz_i == '0);
        load_freq = load_over ? FREQ_MAX_A : freq_hz_i[ACC_W-1:0];
    end

    // Accumulator step, timeout and tick-counter increments shared by ARM/RUN.
    always_comb begin
        sum_run     = acc_q + freq_q;
        wrap        = (sum_run >= F_SYS_A);
        acc_wrapped = sum_run - F_SYS_A;
        to_hit      = (to_q == TO_LAST);
        to_next     = to_hit ? to_q : to_q + TO_W'(1);
        cnt_next    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + C_CNT_BW'(1);
    end

    // FSM next state: a load always wins; ARM leaves on sec_i or on timeout.
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = load_zero ? ST_IDLE : ST_ARM;
        end else begin
            case (state_q)
                ST_ARM: begin
                    if (sec_i || to_hit) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath next values: load, alignment, accumulation and window reports.
    always_comb begin
        acc_d          = acc_q;
        freq_d         = freq_q;
        cnt_d          = cnt_q;
        to_d           = to_q;
        tick_d         = 1'b0;
        sq_d           = sq_q;
        tick_cnt_d     = tick_cnt_q;
        tick_cnt_vld_d = 1'b0;
        ovr_d          = ovr_q;
        phase_err_d    = 1'b0;
        sec_lost_d     = sec_lost_q;

        if (load) begin
            // New request restarts everything; a pending window is dropped.
            freq_d = load_freq;
            ovr_d  = load_over;
            acc_d  = '0;
            sq_d   = 1'b0;
            cnt_d  = '0;
            to_d   = '0;
        end else begin
            case (state_q)
                ST_ARM: begin
                    if (sec_i) begin
                        // First second edge: start one accumulation step in.
                        acc_d = freq_q;
                        cnt_d = '0;
                        to_d  = '0;
                    end else if (to_hit) begin
                        // No second pulse arrived: free-run from phase zero.
                        cnt_d      = '0;
                        sec_lost_d = 1'b1;
                    end else begin
                        to_d = to_q + TO_W'(1);
                    end
                end
                ST_RUN: begin
                    if (sec_i) begin
                        // Re-phase: accumulator restarts from zero, so this
                        // edge adds freq only and can never produce a tick.
                        acc_d          = freq_q;
                        phase_err_d    = (acc_q != '0);
                        tick_cnt_d     = cnt_q;
                        tick_cnt_vld_d = 1'b1;
                        cnt_d          = '0;
                        to_d           = '0;
                        sec_lost_d     = 1'b0;
                    end else begin
                        if (wrap) begin
                            acc_d  = acc_wrapped;
                            tick_d = 1'b1;
                            sq_d   = ~sq_q;
                            cnt_d  = cnt_next;
                        end else begin
                            acc_d = sum_run;
                        end
                        to_d = to_next;
                        if (to_hit) begin
                            sec_lost_d = 1'b1;
                        end
                    end
                end
                default: begin
                    acc_d = acc_q;
                end
            endcase
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q          <= '0;
            freq_q         <= '0;
            cnt_q          <= '0;
            to_q           <= '0;
            tick_q         <= 1'b0;
            sq_q           <= 1'b0;
            tick_cnt_q     <= '0;
            tick_cnt_vld_q <= 1'b0;
            ovr_q          <= 1'b0;
            phase_err_q    <= 1'b0;
            sec_lost_q     <= 1'b0;
        end else begin
            acc_q          <= acc_d;
            freq_q         <= freq_d;
            cnt_q          <= cnt_d;
            to_q           <= to_d;
            tick_q         <= tick_d;
            sq_q           <= sq_d;
            tick_cnt_q     <= tick_cnt_d;
            tick_cnt_vld_q <= tick_cnt_vld_d;
            ovr_q          <= ovr_d;
            phase_err_q    <= phase_err_d;
            sec_lost_q     <= sec_lost_d;
        end
    end

    // Output mapping.
    always_comb begin
        freq_rdy_o     = rdy;
        tick_o         = tick_q;
        sq_o           = sq_q;
        tick_cnt_o     = tick_cnt_q;
        tick_cnt_vld_o = tick_cnt_vld_q;
        ovr_o          = ovr_q;
        phase_err_o    = phase_err_q;
        sec_lost_o     = sec_lost_q;
        dbg_state      = state_q;
    end

endmodule

// File: tb/tb_freq_pulse_gen.sv
// Bench for freq_pulse_gen with a shortened second (F clk cycles).
// The reference model tracks the ideal tick phase as steps*freq/F and
// emits a tick whenever the integer part of that ratio advances.
module tb_freq_pulse_gen;
    localparam int F = 100;
    localparam int W = 32;
    localparam int M_IDLE = 0;
    localparam int M_ARM  = 1;
    localparam int M_RUN  = 2;

    // ---------------- clock / reset / DUT ----------------
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         sec_i = 1'b0;
    logic [W-1:0] freq_hz_i = '0;
    logic         freq_vld_i = 1'b0;
    logic         freq_rdy_o;
    logic         tick_o;
    logic         sq_o;
    logic [W-1:0] tick_cnt_o;
    logic         tick_cnt_vld_o;
    logic         ovr_o;
    logic         phase_err_o;
    logic         sec_lost_o;
    logic [1:0]   dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;

    freq_pulse_gen #(
        .SYS_PRD_NS(10),
        .C_F_SYS   (F),
        .C_CNT_BW  (W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .sec_i         (sec_i),
        .freq_hz_i     (freq_hz_i),
        .freq_vld_i    (freq_vld_i),
        .freq_rdy_o    (freq_rdy_o),
        .tick_o        (tick_o),
        .sq_o          (sq_o),
        .tick_cnt_o    (tick_cnt_o),
        .tick_cnt_vld_o(tick_cnt_vld_o),
        .ovr_o         (ovr_o),
        .phase_err_o   (phase_err_o),
        .sec_lost_o    (sec_lost_o),
        .dbg_state     (dbg_state)
    );

    // ---------------- reference model ----------------
    bit           m_init = 1'b0;
    int           m_mode = M_IDLE;
    longint       m_f = 0;
    longint       m_steps = 0;
    int           m_since = 0;
    logic [W-1:0] m_cnt = '0;
    logic         e_tick = 1'b0, e_sq = 1'b0, e_vld = 1'b0, e_ovr = 1'b0;
    logic         e_perr = 1'b0, e_lost = 1'b0;
    logic [W-1:0] e_cnt = '0;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_init = 1'b1;
            m_mode = M_IDLE; m_f = 0; m_steps = 0; m_since = 0; m_cnt = '0;
            e_tick = 0; e_sq = 0; e_cnt = '0; e_vld = 0; e_ovr = 0; e_perr = 0; e_lost = 0;
        end else begin
            e_tick = 0; e_vld = 0; e_perr = 0;
            if (freq_vld_i && m_mode != M_ARM) begin
                e_ovr   = (longint'(freq_hz_i) > F / 2);
                m_f     = e_ovr ? F / 2 : longint'(freq_hz_i);
                m_mode  = (freq_hz_i == 0) ? M_IDLE : M_ARM;
                m_steps = 0; m_since = 0; m_cnt = '0; e_sq = 0;
            end else if (m_mode == M_ARM) begin
                m_since++;
                if (sec_i) begin
                    m_mode = M_RUN; m_steps = 1; m_since = 0; m_cnt = '0;
                end else if (m_since >= 2 * F) begin
                    m_mode = M_RUN; m_steps = 0; m_cnt = '0; e_lost = 1;
                end
            end else if (m_mode == M_RUN) begin
                if (sec_i) begin
                    e_perr  = ((m_steps * m_f) % F) != 0;
                    e_cnt   = m_cnt;
                    e_vld   = 1;
                    m_cnt   = '0; m_steps = 1; m_since = 0; e_lost = 0;
                end else begin
                    if (((m_steps + 1) * m_f) / F > (m_steps * m_f) / F) begin
                        e_tick = 1;
                        e_sq   = ~e_sq;
                        if (m_cnt != '1) m_cnt++;
                    end
                    m_steps++;
                    m_since++;
                    if (m_since >= 2 * F) e_lost = 1;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (m_init) begin
            n_tests++;
            if ({tick_o, sq_o, tick_cnt_vld_o, ovr_o, phase_err_o, sec_lost_o, freq_rdy_o} !==
                {e_tick, e_sq, e_vld, e_ovr, e_perr, e_lost, (m_mode != M_ARM)} ||
                (e_vld && tick_cnt_o !== e_cnt)) begin
                n_fail++;
                $display("FAIL model cyc=%0d: got tick=%0b sq=%0b vld=%0b cnt=%0d ovr=%0b perr=%0b lost=%0b rdy=%0b / exp tick=%0b sq=%0b vld=%0b cnt=%0d ovr=%0b perr=%0b lost=%0b rdy=%0b",
                         cyc, tick_o, sq_o, tick_cnt_vld_o, tick_cnt_o, ovr_o, phase_err_o, sec_lost_o, freq_rdy_o,
                         e_tick, e_sq, e_vld, e_cnt, e_ovr, e_perr, e_lost, (m_mode != M_ARM));
            end
        end
    end

    // ---------------- driver / literal checks ----------------
    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input int unsigned v);
        freq_hz_i  = v;
        freq_vld_i = 1'b1;
        @(negedge clk);
        freq_vld_i = 1'b0;
    endtask

    // Pulse sec_i for one cycle, check the report for the window it closes,
    // then wait so the next call lands exactly `period` cycles later.
    task automatic sec_win(input int period, input bit exp_vld, input int unsigned exp_cnt,
                           input bit exp_perr, input string tag);
        sec_i = 1'b1;
        @(negedge clk);
        sec_i = 1'b0;
        chk({tag, "_vld"}, W'(tick_cnt_vld_o), W'(exp_vld));
        if (exp_vld) begin
            chk({tag, "_cnt"}, tick_cnt_o, exp_cnt);
            chk({tag, "_perr"}, W'(phase_err_o), W'(exp_perr));
        end
        wait_cyc(period - 1);
    endtask

    initial begin
        int ticks;
        int vlds;

        // reset, with a request presented during reset that must be ignored
        freq_hz_i = 25;
        freq_vld_i = 1'b1;
        wait_cyc(3);
        freq_vld_i = 1'b0;
        chk("rst_tick", W'(tick_o), 0);
        chk("rst_sq", W'(sq_o), 0);
        chk("rst_rdy", W'(freq_rdy_o), 1);
        chk("rst_cnt", tick_cnt_o, 0);
        chk("rst_ovr", W'(ovr_o), 0);
        chk("rst_lost", W'(sec_lost_o), 0);
        rst = 1'b0;
        wait_cyc(3);
        chk("idle_rdy", W'(freq_rdy_o), 1);

        // 1. exact rate 25 Hz
        load(25);
        chk("t1_rdy_arm", W'(freq_rdy_o), 0);
        wait_cyc(5);
        sec_i = 1'b1;
        @(negedge clk);
        sec_i = 1'b0;
        chk("t1_tick_n1", W'(tick_o), 0);
        wait_cyc(2);
        chk("t1_tick_n3", W'(tick_o), 0);
        wait_cyc(1);
        chk("t1_tick_n4", W'(tick_o), 1);
        wait_cyc(96);
        chk("t1_tick_n100", W'(tick_o), 1);
        sec_win(100, 1, 25, 0, "t1_w1");

        // 2. uneven rate 30 Hz, three windows
        load(30);
        sec_win(100, 0, 0, 0, "t2_arm");
        sec_win(100, 1, 30, 0, "t2_w1");
        sec_win(100, 1, 30, 0, "t2_w2");
        sec_win(100, 1, 30, 0, "t2_w3");

        // 3. clamp then zero
        load(80);
        chk("t3_ovr", W'(ovr_o), 1);
        sec_win(100, 0, 0, 0, "t3_arm");
        sec_win(100, 1, 50, 0, "t3_w1");
        load(0);
        chk("t3_zero_ovr", W'(ovr_o), 0);
        chk("t3_zero_rdy", W'(freq_rdy_o), 1);
        wait_cyc(20);
        chk("t3_idle_tick", W'(tick_o), 0);
        chk("t3_idle_sq", W'(sq_o), 0);

        // 4. phase error with a 97-cycle second, then resync
        load(25);
        sec_win(97, 0, 0, 0, "t4_arm");
        sec_win(97, 1, 24, 1, "t4_a");
        sec_win(100, 1, 24, 1, "t4_b");
        sec_win(10, 1, 25, 0, "t4_resync");

        // 5. lost second in RUN, then restored
        load(10);
        sec_win(100, 0, 0, 0, "t5_arm");
        sec_win(100, 1, 10, 0, "t5_w1");
        wait_cyc(100);
        chk("t5_lost_200", W'(sec_lost_o), 0);
        wait_cyc(1);
        chk("t5_lost_201", W'(sec_lost_o), 1);
        ticks = 0;
        vlds = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tick_o) ticks++;
            if (tick_cnt_vld_o) vlds++;
        end
        chk("t5_free_ticks", ticks, 10);
        chk("t5_no_vld", vlds, 0);
        wait_cyc(99);
        sec_win(30, 1, 40, 0, "t5_restore");
        chk("t5_lost_clr", W'(sec_lost_o), 0);

        // 6. ARM timeout into free-run, reset mid-window, reload mid-RUN
        load(90);
        chk("t6_ovr", W'(ovr_o), 1);
        wait_cyc(199);
        chk("t6_arm_lost0", W'(sec_lost_o), 0);
        chk("t6_arm_rdy0", W'(freq_rdy_o), 0);
        wait_cyc(1);
        chk("t6_arm_lost1", W'(sec_lost_o), 1);
        chk("t6_run_rdy", W'(freq_rdy_o), 1);
        wait_cyc(33);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_tick", W'(tick_o), 0);
        chk("t6_rst_sq", W'(sq_o), 0);
        chk("t6_rst_ovr", W'(ovr_o), 0);
        chk("t6_rst_lost", W'(sec_lost_o), 0);
        chk("t6_rst_rdy", W'(freq_rdy_o), 1);
        rst = 1'b0;
        wait_cyc(2);
        load(25);
        sec_win(50, 0, 0, 0, "t6_arm");
        load(30);
        chk("t6_reload_rdy", W'(freq_rdy_o), 0);
        wait_cyc(20);
        chk("t6_wait_rdy", W'(freq_rdy_o), 0);
        sec_win(100, 0, 0, 0, "t6_rearm");
        chk("t6_rearm_rdy", W'(freq_rdy_o), 1);
        sec_win(100, 1, 30, 0, "t6_win");
        // load and sec_i on the same edge: load wins, no report
        freq_hz_i  = 40;
        freq_vld_i = 1'b1;
        sec_i      = 1'b1;
        @(negedge clk);
        freq_vld_i = 1'b0;
        sec_i      = 1'b0;
        chk("t6_sim_vld", W'(tick_cnt_vld_o), 0);
        chk("t6_sim_rdy", W'(freq_rdy_o), 0);
        wait_cyc(5);
        sec_win(100, 0, 0, 0, "t6_sim_arm");
        sec_win(5, 1, 40, 0, "t6_sim_w1");

        wait_cyc(5);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog: the directed sequence is far shorter than this.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
